ghost_controller: RTL

//  Autonomous ghost for the maze game. Patrols the three-lane corridor grid
//  (lanes at 50/220/390 on each axis, between the blue boxes). Turns only at

---
 rtl/ghost_controller_pkg.sv | 54 +++++
 rtl/ghost_lfsr8.sv | 29 ++
 rtl/ghost_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ghost_controller_pkg.sv
// ghost_controller_pkg
//   Maze-wide constants and helpers shared by the ghost, the player movement
//   logic and the draw logic: heading encodings, corridor lane positions,
//   coordinate widths, the position payload and small lane/heading helpers.
package ghost_controller_pkg;

  // Screen coordinate widths
  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  // Corridor lane centres, identical on both axes
  localparam int unsigned LANE_LO  = 50;
  localparam int unsigned LANE_MID = 220;
  localparam int unsigned LANE_HI  = 390;

  // Galois feedback taps for the 8-bit right-shifting LFSR
  localparam logic [7:0] LFSR_MASK = 8'hB8;

  // Heading encoding; index order doubles as the exit scan order
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_LEFT  = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  // Sprite centre position as passed to the draw logic
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  // True when a coordinate sits exactly on one of the three lanes
  function automatic logic on_lane(input logic [X_W-1:0] v);
    return (v == X_W'(LANE_LO)) || (v == X_W'(LANE_MID)) || (v == X_W'(LANE_HI));
  endfunction

  // Opposite heading: UP<->DOWN, LEFT<->RIGHT differ only in bit 1
  function automatic dir_t dir_reverse(input dir_t d);
    return d ^ 2'b10;
  endfunction

  // First set bit of ok, scanning cyclically upward from index start
  function automatic dir_t scan_exits(input logic [3:0] ok, input dir_t start);
    dir_t idx;
    dir_t pick;
    pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (ok[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ghost_lfsr8.sv
// ghost_lfsr8
//   8-bit Galois LFSR, right shifting, taps from LFSR_MASK. Advances one
//   state per cycle while en is high and reloads SEED on reset.
// Ports
//   clk    in   clock
//   reset  in   asynchronous, active-high
//   en     in   advance one state this cycle
//   q      out  current LFSR state (registered)
module ghost_lfsr8
  import ghost_controller_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  // Shift right; the bit falling out of q[0] injects the tap pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= SEED;
    end else if (en) begin
      q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_MASK : 8'h00);
    end
  end

endmodule

// File: rtl/ghost_controller.sv
// ghost_controller
//   Autonomous maze ghost. Walks the three-lane corridor grid one STEP per
//   TICK_DIV clocks, turning only at lane intersections. Turns chase the
//   player or, when the LFSR says so, pick a pseudo-random exit.
// Ports
//   clk        in   board clock
//   reset      in   asynchronous, active-high
//   run        in   1 = move; 0 = freeze divider, position and LFSR
//   pac_x      in   player centre x
//   pac_y      in   player centre y
//   ghost_x    out  ghost centre x (registered)
//   ghost_y    out  ghost centre y (registered)
//   ghost_dir  out  heading 0 UP, 1 LEFT, 2 DOWN, 3 RIGHT (registered)
//   step_stb   out  high for the cycle in which ghost_x/y have just changed
//   collide    out  registered ghost/player overlap flag
module ghost_controller
  import ghost_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter int unsigned STEP     = 10,
  parameter int unsigned START_X  = 390,
  parameter int unsigned START_Y  = 390,
  parameter int unsigned HIT_R    = 11,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [X_W-1:0] pac_x,
  input  logic [Y_W-1:0] pac_y,
  output logic [X_W-1:0] ghost_x,
  output logic [Y_W-1:0] ghost_y,
  output logic [1:0]     ghost_dir,
  output logic           step_stb,
  output logic           collide
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam int unsigned DX_W = X_W + 1;
  localparam int unsigned DY_W = Y_W + 1;

  logic [X_W-1:0]   pac_x_q;
  logic [Y_W-1:0]   pac_y_q;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       lfsr;
  logic             fire;

  logic             at_cross;
  logic [3:0]       legal;
  logic [3:0]       allowed;
  dir_t             rev;

  logic signed [DX_W-1:0] dx;
  logic signed [DY_W-1:0] dy;
  logic [DX_W-1:0]  adx;
  logic [DY_W-1:0]  ady;
  dir_t             dir_h;
  dir_t             dir_v;
  dir_t             prim_dir;
  dir_t             sec_dir;
  logic             prim_valid;
  logic             sec_valid;
  dir_t             first_dir;
  dir_t             rnd_dir;
  dir_t             chase_dir;
  logic             chase_mode;
  dir_t             new_dir;
  pos_t             pos_next;
  logic             hit;
  logic             unused_lfsr_hi;

  // Step fires on the edge that would wrap the divider, only while running
  assign fire = run && (div_cnt == DIV_LAST);

  ghost_lfsr8 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (fire),
    .q     (lfsr)
  );

  // Only lfsr[3:0] steers the chooser
  assign unused_lfsr_hi = ^lfsr[7:4];

  // Intersection detect and exits that stay inside the 50..390 box
  assign at_cross = on_lane(ghost_x) && on_lane({1'b0, ghost_y});
  assign rev      = dir_reverse(ghost_dir);
  assign legal    = {ghost_x < X_W'(LANE_HI),    // RIGHT
                     ghost_y < Y_W'(LANE_HI),    // DOWN
                     ghost_x > X_W'(LANE_LO),    // LEFT
                     ghost_y > Y_W'(LANE_LO)};   // UP

  // Drop the reversal unless it is the only way out (a dead-end corner)
  always_comb begin
    allowed = legal & ~(4'b0001 << rev);
    if (allowed == 4'b0000) allowed = legal;
  end

  // Signed offsets to the player and their magnitudes
  assign dx  = $signed({1'b0, pac_x_q}) - $signed({1'b0, ghost_x});
  assign dy  = $signed({1'b0, pac_y_q}) - $signed({1'b0, ghost_y});
  assign adx = dx[DX_W-1] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[DY_W-1] ? $unsigned(-dy) : $unsigned(dy);

  assign dir_h = dx[DX_W-1] ? DIR_LEFT : DIR_RIGHT;
  assign dir_v = dy[DY_W-1] ? DIR_UP   : DIR_DOWN;

  assign first_dir  = scan_exits(allowed, DIR_UP);
  assign rnd_dir    = scan_exits(allowed, lfsr[3:2]);
  assign chase_mode = (lfsr[1:0] != 2'b00);

  // Chase: larger-offset axis first (ties horizontal), then the other axis,
  // then the fixed-order fallback. A zero offset gives no toward direction.
  always_comb begin
    prim_dir   = dir_h;
    prim_valid = (dx != '0);
    sec_dir    = dir_v;
    sec_valid  = (dy != '0);
    if (adx < {1'b0, ady}) begin
      prim_dir   = dir_v;
      prim_valid = (dy != '0);
      sec_dir    = dir_h;
      sec_valid  = (dx != '0);
    end
    chase_dir = first_dir;
    if (sec_valid && allowed[sec_dir])   chase_dir = sec_dir;
    if (prim_valid && allowed[prim_dir]) chase_dir = prim_dir;
  end

  // Heading for this step and the position one STEP along it
  always_comb begin
    new_dir = ghost_dir;
    if (at_cross) new_dir = chase_mode ? chase_dir : rnd_dir;
    pos_next.x = ghost_x;
    pos_next.y = ghost_y;
    case (new_dir)
      DIR_UP:    pos_next.y = ghost_y - Y_W'(STEP);
      DIR_LEFT:  pos_next.x = ghost_x - X_W'(STEP);
      DIR_DOWN:  pos_next.y = ghost_y + Y_W'(STEP);
      default:   pos_next.x = ghost_x + X_W'(STEP);
    endcase
  end

  assign hit = (adx < DX_W'(HIT_R)) && (ady < DY_W'(HIT_R));

  // Player sampling, collision flag, step divider and ghost state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pac_x_q   <= '0;
      pac_y_q   <= '0;
      collide   <= 1'b0;
      step_stb  <= 1'b0;
      div_cnt   <= '0;
      ghost_x   <= X_W'(START_X);
      ghost_y   <= Y_W'(START_Y);
      ghost_dir <= DIR_LEFT;
    end else begin
      pac_x_q  <= pac_x;
      pac_y_q  <= pac_y;
      collide  <= hit;
      step_stb <= fire;
      if (run) div_cnt <= fire ? '0 : div_cnt + DIV_W'(1);
      if (fire) begin
        ghost_x   <= pos_next.x;
        ghost_y   <= pos_next.y;
        ghost_dir <= new_dir;
      end
    end
  end

endmodule
